// File: rtl/argmax_classifier_pkg.sv
// Shared constants and types for the argmax output-decision stage.
package argmax_classifier_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 16;
  localparam int IDX_W       = 4;

  localparam logic signed [DATA_W-1:0] DATA_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] DATA_MIN = 16'sh8000;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/argmax_classifier_if.sv
// Network-core / consumer side signals of the argmax classifier.
interface argmax_classifier_if #(
  parameter int NUM_CLASSES = argmax_classifier_pkg::NUM_CLASSES,
  parameter int DATA_W      = argmax_classifier_pkg::DATA_W
);
  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic                                R;
  logic [NUM_CLASSES-1:0][DATA_W-1:0]  Probability;
  logic                                Ack;
  logic                                Busy;
  logic                                Valid;
  logic [IDX_W-1:0]                    Digit;
  logic [DATA_W-1:0]                   Score;
  logic [DATA_W-1:0]                   Margin;
  logic                                Overrun;

  modport master (output R, Probability, Ack,
                  input  Busy, Valid, Digit, Score, Margin, Overrun);
  modport slave  (input  R, Probability, Ack,
                  output Busy, Valid, Digit, Score, Margin, Overrun);
endinterface

// File: rtl/argmax_classifier_update.sv
// One-candidate best/second/best_idx update; strict compares keep the lowest index on ties.
module argmax_update #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     first,
  input  logic signed [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]         cand_idx,
  input  logic signed [DATA_W-1:0] best_i,
  input  logic signed [DATA_W-1:0] second_i,
  input  logic [IDX_W-1:0]         best_idx_i,
  output logic signed [DATA_W-1:0] best_o,
  output logic signed [DATA_W-1:0] second_o,
  output logic [IDX_W-1:0]         best_idx_o
);
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  always_comb begin
    best_o     = best_i;
    second_o   = second_i;
    best_idx_o = best_idx_i;
    if (first) begin
      best_o     = cand;
      best_idx_o = cand_idx;
      second_o   = SMIN;
    end else if (cand > best_i) begin
      second_o   = best_i;
      best_o     = cand;
      best_idx_o = cand_idx;
    end else if (cand > second_i) begin
      second_o   = cand;
    end
  end
endmodule

// File: rtl/argmax_classifier.sv
// Snapshots the output-layer activations on R rising and scans one class per cycle,
// presenting digit/score/margin through a Valid/Ack handshake.
module argmax_classifier #(
  parameter int NUM_CLASSES = argmax_classifier_pkg::NUM_CLASSES,
  parameter int DATA_W      = argmax_classifier_pkg::DATA_W
) (
  input  logic                 Clk,
  input  logic                 Reset,
  argmax_classifier_if.slave   bus
);
  import argmax_classifier_pkg::*;

  localparam int IDX_W = $clog2(NUM_CLASSES);
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(NUM_CLASSES-1);

  state_t                              state;
  logic                                r_d;
  logic [NUM_CLASSES-1:0][DATA_W-1:0]  snap;
  logic [IDX_W-1:0]                    idx;
  logic signed [DATA_W-1:0]            best, second, nxt_best, nxt_second;
  logic [IDX_W-1:0]                    best_idx, nxt_best_idx;
  logic signed [DATA_W:0]              diff;
  logic [DATA_W-1:0]                   margin_sat;
  logic                                start;

  logic                                busy_q, valid_q, overrun_q;
  logic [IDX_W-1:0]                    digit_q;
  logic [DATA_W-1:0]                   score_q, margin_q;

  assign start = bus.R & ~r_d;

  argmax_update #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_upd (
    .first      (idx == '0),
    .cand       ($signed(snap[idx])),
    .cand_idx   (idx),
    .best_i     (best),
    .second_i   (second),
    .best_idx_i (best_idx),
    .best_o     (nxt_best),
    .second_o   (nxt_second),
    .best_idx_o (nxt_best_idx)
  );

  // best >= second always holds, so the 17-bit difference is non-negative.
  assign diff       = {nxt_best[DATA_W-1], nxt_best} - {nxt_second[DATA_W-1], nxt_second};
  assign margin_sat = (diff[DATA_W] | diff[DATA_W-1]) ? SAT_MAX : diff[DATA_W-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      r_d       <= 1'b1;
      snap      <= '0;
      idx       <= '0;
      best      <= '0;
      second    <= '0;
      best_idx  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      digit_q   <= '0;
      score_q   <= '0;
      margin_q  <= '0;
    end else begin
      r_d <= bus.R;
      if (start && state != IDLE) overrun_q <= 1'b1;
      case (state)
        IDLE: if (start) begin
          snap   <= bus.Probability;
          idx    <= '0;
          busy_q <= 1'b1;
          state  <= SCAN;
        end
        SCAN: begin
          best     <= nxt_best;
          second   <= nxt_second;
          best_idx <= nxt_best_idx;
          if (idx == LAST) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            digit_q  <= nxt_best_idx;
            score_q  <= nxt_best;
            margin_q <= margin_sat;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (bus.Ack) begin
          valid_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy    = busy_q;
  assign bus.Valid   = valid_q;
  assign bus.Digit   = digit_q;
  assign bus.Score   = score_q;
  assign bus.Margin  = margin_q;
  assign bus.Overrun = overrun_q;
endmodule

// File: doc/argmax_classifier.md
# argmax_classifier

Output-decision stage placed directly downstream of the neural network core. When the network signals completion, it snapshots the ten 16-bit output-layer activations and scans them sequentially, one class per cycle. It then presents the winning digit, its score, and the margin over the runner-up to the display/UART consumer through a valid/ack handshake.

## Interface
Parameters:
- NUM_CLASSES, 10, number of output activations scanned; fixes Digit width at 4.
- DATA_W, 16, activation width; signed two's complement.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high.
- R  in  1  network-done level from the network core; activations are valid while high.
- Probability  in  DATA_W x [NUM_CLASSES-1:0]  output-layer activations, signed.
- Ack  in  1  consumer has taken the result.
- Busy  out  1  high from capture through the end of scan.
- Valid  out  1  result available; held until Ack.
- Digit  out  4  index of the maximum activation.
- Score  out  DATA_W  activation value at Digit.
- Margin  out  DATA_W  Score minus the second-highest activation, saturated.
- Overrun  out  1  sticky; a new R rising edge arrived while Busy or Valid.

## Operation
- R_d: registered copy of R. Start event = R & ~R_d.
- States:
  - IDLE: on start, latch all ten Probability words into a snapshot, idx <= 0, go to SCAN, Busy <= 1.
  - SCAN: one class per cycle; after idx 9 is processed, go to DONE, Busy <= 0, Valid <= 1, outputs loaded.
  - DONE: hold Valid and the outputs stable; Ack -> IDLE with Valid <= 0.
- Per-step update, v = snap[idx], signed compare:
  - idx 0: best <= v, best_idx <= 0, second <= -32768.
  - v > best: second <= best, best <= v, best_idx <= idx.
  - else if v > second: second <= v.
  - Comparisons are strict, so on ties the lowest index wins.
- Margin = best - second computed at 17 bits; results above 32767 saturate to 16'h7FFF. The result is never negative.
- Start events during SCAN or DONE are ignored and set Overrun. Overrun clears only on Reset.
- Ack outside DONE has no effect.
- Probability is not sampled after the capture cycle, so later input changes do not affect the result.

## Timing
- Reset values:
  - Valid = Busy = Overrun = 0.
  - Digit = 0, Score = 0, Margin = 0.
  - State IDLE.
  - R_d = 1, so an R level held through Reset does not trigger a start.
- Latency: start sampled at edge k -> Valid high after edge k+10, with Busy high after edges k..k+9.
- Handshake: Ack sampled high at edge j while Valid -> Valid low after edge j. If a start coincides with that Ack in DONE, it counts as an overrun and is not captured.
- Throughput: one classification per 11 cycles minimum (capture + 10 scan), plus the Ack cycle.
- Reset during SCAN or DONE aborts the operation; no partial result is ever presented.

## Structure
- Shared package (BRAM_ADDRS companion, e.g. NN_PKG) holds:
  - NUM_CLASSES and DATA_W constants.
  - the state enum typedef {IDLE, SCAN, DONE}.
  - the saturation constants DATA_MAX and DATA_MIN.
- One natural sub-module: argmax_update, a combinational best/second/best_idx update for one candidate. The top holds the FSM, snapshot, counter and handshake.

## Test plan
- Distinct values, max at index 7 (snap = 0,...,0x0300 at idx7, 0x0100 at idx2) -> Digit 7, Score 0x0300, Margin 0x0200; Valid exactly 10 cycles after start.
- All ten equal to 0x0080 -> Digit 0, Score 0x0080, Margin 0.
- All negative, max -1 at idx9, others -0x4000 -> Digit 9, Score 0xFFFF, Margin 0x3FFF. Then max 0x7FFF with all others 0x8000 -> Margin saturates to 0x7FFF.
- Pulse R again mid-SCAN and again during DONE -> result unchanged, Overrun = 1. Ack -> Valid falls next edge; fresh R edge starts a new scan.
- Hold Ack low for 50 cycles with Probability changing -> Valid, Digit, Score and Margin stable.
- Assert Reset at scan step 5 -> all outputs 0 next edge. With R held high through Reset, no start until R falls and rises again.
